// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type, slice width and op encoding for the sequential add/subtract block.
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_addsub.sv
// nibble_addsub: combinational W-bit add/subtract slice, s = a + (b ^ {W{sub}}) + cin.
// Ports: a, b (W-bit operands), sub (invert b), cin (carry in), s (W-bit result), cout (carry out).
module nibble_addsub
    import addsub_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, cin};
endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: WIDTH-bit add/subtract computed one SLICE-bit slice per clock through a shared slice.
// Ports: clk, rst (async, active-high); request handshake req_valid/req_ready with op_a, op_b, op_sub;
// response handshake rsp_valid/rsp_ready with sum, cout (subtract: 1 = no borrow), ovf (signed overflow);
// busy is high while an operation is in flight or waiting to be taken.
// Build option ADDSUB_SEQ_ACC_EN adds acc_sel and an accumulator that captures every delivered sum
// and can replace op_a on accept.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
`ifdef ADDSUB_SEQ_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of SLICE");
    end

    state_t            state, state_nx;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              sub_r;
    logic [SLICE-1:0]  s_s;
    logic              s_cout;
    logic              accept, last;
    logic [WIDTH-1:0]  a_in;

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign last      = (idx == IW'(N - 1));

`ifdef ADDSUB_SEQ_ACC_EN
    logic [WIDTH-1:0] acc;
    assign a_in = acc_sel ? acc : op_a;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (rsp_valid && rsp_ready)
            acc <= sum;
    end
`else
    assign a_in = op_a;
`endif

    nibble_addsub #(.W(SLICE)) u_slice (
        .a    (a_r[idx*SLICE +: SLICE]),
        .b    (b_r[idx*SLICE +: SLICE]),
        .sub  (sub_r),
        .cin  (carry),
        .s    (s_s),
        .cout (s_cout)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= OP_ADD;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && accept) begin
            a_r   <= a_in;
            b_r   <= op_b;
            sub_r <= op_sub;
            carry <= op_sub;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*SLICE +: SLICE] <= s_s;
            carry <= s_cout;
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= s_cout;
                // top result bit comes straight from the slice on the final pass
                ovf  <= (a_r[WIDTH-1] ^ s_s[SLICE-1]) & (b_r[WIDTH-1] ^ sub_r ^ s_s[SLICE-1]);
            end
        end
    end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: directed and randomized checks of addsub_seq_ctrl against an arithmetic reference model.
module tb_addsub_seq_ctrl;
    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_sub = 1'b0;
    logic         acc_sel = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] acc_m = '0;

    always #5 clk = ~clk;

    addsub_seq_ctrl #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
`ifdef ADDSUB_SEQ_ACC_EN
        .acc_sel   (acc_sel),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference: plain integer arithmetic; signed overflow = true result outside 16-bit signed range
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] s, output logic c, output logic v);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s = W'(ua - ub);
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            s = W'(ua + ub);
            c = (ua + ub) > 65535;
            r = sa + sb;
        end
        v = (r > 32767) || (r < -32768);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic sel);
        int t;
        op_a = a;
        op_b = b;
        op_sub = sub;
        acc_sel = sel;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            tick();
            t++;
        end
        if (!req_ready)
            check("req_ready_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        op_sub = $urandom;
    endtask

    // called right after the accept edge; checks latency, result, hold and handshake
    task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
        logic [W-1:0] es;
        logic ec, ev;
        model(a, b, sub, es, ec, ev);
        for (int i = 1; i < N; i++) tick();
        check("latency_early", 32'(rsp_valid), 32'd0);
        tick();
        check("latency_valid", 32'(rsp_valid), 32'd1);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_cout", 32'(cout), 32'(ec));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        acc_m = es;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
        start(a, b, sub, 1'b0);
        finish(a, b, sub, hold);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        op(16'h1234, 16'h0FFF, 1'b0, 0);
        op(16'h0005, 16'h0007, 1'b1, 0);
        op(16'h0007, 16'h0005, 1'b1, 0);
        op(16'h7FFF, 16'h0001, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 0);
        op(16'h8000, 16'h0001, 1'b1, 0);

        // backpressure with a new request waiting behind the response
        start(16'hABCD, 16'h1111, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) tick();
        tick();
        check("bp_valid", 32'(rsp_valid), 32'd1);
        op_a = 16'h0102;
        op_b = 16'h0304;
        op_sub = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_sum", 32'(sum), 32'hBCDE);
            check("bp_hold_cout", 32'(cout), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bubble_idle", 32'(busy), 32'd0);
        check("bubble_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("bubble_accept", 32'(busy), 32'd1);
        finish(16'h0102, 16'h0304, 1'b0, 0);

        // reset in the middle of RUN
        start(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        acc_m = '0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        op(16'h0001, 16'h0001, 1'b0, 0);

`ifdef ADDSUB_SEQ_ACC_EN
        op(16'h0010, 16'h0000, 1'b0, 0);
        start(16'hAAAA, 16'h0001, 1'b0, 1'b1);
        finish(16'h0010, 16'h0001, 1'b0, 0);
`endif

        for (int k = 0; k < 25; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom;
`ifdef ADDSUB_SEQ_ACC_EN
            if (k % 4 == 3) begin
                start(ra, rb, rs, 1'b1);
                finish(acc_m, rb, rs, $urandom_range(0, 2));
                continue;
            end
`endif
            op(ra, rb, rs, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Sequencer that reuses one 4-bit add/subtract slice to perform WIDTH-bit add or subtract, one nibble per clock, least significant nibble first.
- Sits between a requester and a single shared slice datapath: accepts an operation over a valid/ready handshake, sequences the slice with a registered carry, and returns the result, carry and overflow over a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE (elaboration error otherwise).
- SLICE, 4, bits processed per cycle (slice width); N = WIDTH/SLICE passes per operation.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- op_a, input, WIDTH, operand A.
- op_b, input, WIDTH, operand B.
- op_sub, input, 1, 0 = A+B, 1 = A-B.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer takes result.
- sum, output, WIDTH, result.
- cout, output, 1, final carry; for subtract 1 = no borrow.
- ovf, output, 1, two's-complement signed overflow.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Reset values: state IDLE, slice index 0, carry 0, sum 0, cout 0, ovf 0, rsp_valid 0, busy 0. req_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch op_a, op_b, op_sub; carry <= op_sub; idx <= 0; go to RUN.
- RUN, one slice per cycle:
  - Slice inputs: a=A[idx*SLICE +: SLICE], b=B[idx*SLICE +: SLICE], sub=op_sub, cin=carry.
  - Slice computes a + (b ^ {SLICE{sub}}) + cin.
  - At the clock edge: write the slice result into sum[idx*SLICE +: SLICE], carry <= slice cout, idx++.
  - When idx==N-1: go to DONE, set cout <= slice cout, and ovf <= (A[W-1] ^ r[W-1]) & (Beff[W-1] ^ r[W-1]), where Beff = B ^ {W{sub}} and r is the final result.
- Latency: rsp_valid rises exactly N cycles after the accepting edge (4 for defaults).
- sum is updated progressively during RUN and is valid only while rsp_valid=1.
- DONE:
  - rsp_valid=1; sum, cout and ovf are held stable.
  - On rsp_ready: rsp_valid falls and the FSM goes to IDLE.
  - req_ready=0 throughout RUN and DONE. A request presented in the same cycle as the response handshake is accepted on the following IDLE cycle (one-cycle bubble).
- Arithmetic: all wrap modulo 2^WIDTH. No saturation.
- Reset mid-operation (RUN or DONE): immediate abort, all state to reset values, partial result discarded.
- Inputs op_a/op_b/op_sub are ignored outside the accept cycle.

Optional Feature:
- Macro: ADDSUB_SEQ_ACC_EN.
- Defined:
  - Adds input port acc_sel (1 bit) and an internal accumulator register, reset to 0.
  - On each completed response handshake the accumulator loads sum.
  - On accept with acc_sel=1, operand A is taken from the accumulator instead of op_a.
- Undefined: no acc_sel port, no accumulator register; operand A is always op_a.

Decomposition:
- Shared package addsub_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - SLICE_W=4;
  - an op encoding constant (OP_ADD=0, OP_SUB=1).
- One natural sub-module, nibble_addsub:
  - combinational SLICE-bit add/subtract with inputs a, b, sub, cin and outputs s, cout;
  - instantiated once inside the controller.

Test Plan:
- 0x1234 + 0x0FFF, op_sub=0 -> sum 0x2233, cout 0, ovf 0; rsp_valid exactly 4 cycles after accept.
- 0x0005 - 0x0007, op_sub=1 -> sum 0xFFFE, cout 0 (borrow), ovf 0. Then 0x0007 - 0x0005 -> 0x0002, cout 1.
- 0x7FFF + 0x0001 -> 0x8000, ovf 1, cout 0. Then 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0. Then 0x8000 - 0x0001 -> 0x7FFF, ovf 1.
- Backpressure: rsp_ready held low 3 cycles in DONE -> rsp_valid, sum and cout stable; req_ready 0. A new req_valid held high is accepted the cycle after the response handshake.
- rst pulsed during RUN at idx 2 -> rsp_valid 0, busy 0, sum 0. After release, req_ready=1 and a fresh 0x0001 + 0x0001 returns 0x0002.
- With ADDSUB_SEQ_ACC_EN: first op 0x0010 + 0x0000, then acc_sel=1 with op_b=0x0001 and op_a=0xAAAA -> sum 0x0011.
